mac_rx_stream: RTL and testbench
================================

# mac_rx_stream

Parametrised receive MAC for the byte-stream datapath. It accepts full frames (header, payload, pad and FCS), checks the CRC-32 and the frame length, and forwards the frame on a backpressured output stream. The FCS is optionally stripped, oversize frames are truncated, and an error flag is attached to the last output beat. It also keeps saturating per-class frame counters and sits between the byte-level PHY adapter and the frame consumers.

## Interface
- `MIN_LEN`, default 64: minimum legal frame length in bytes, FCS included.
- `MAX_LEN`, default 1518: maximum legal frame length in bytes, FCS included; must be ≥ `MIN_LEN` and ≥ 5.
- `STRIP_FCS`, default 1: 1 = the 4 FCS bytes are not forwarded; 0 = all bytes are forwarded.
- `CNT_W`, default 32: width of the statistics counters.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: input byte accepted when `in_valid && in_ready`.
- `in_data` in 8: input byte, in wire order.
- `in_last` in 1: last byte of the frame.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: consumer ready.
- `out_data` out 8: output byte.
- `out_last` out 1: last forwarded beat of the frame.
- `out_err` out 1: frame is bad; meaningful only when `out_last` is 1.
- `frame_good` out 1: one-cycle status pulse.
- `frame_bad_crc` out 1: one-cycle status pulse.
- `frame_bad_len` out 1: one-cycle status pulse.
- `frame_len_total` out 16: length of the last completed frame, FCS included; holds until the next completion.
- `stat_clr` in 1: synchronous clear of all counters.
- `cnt_good` out `CNT_W`: frames with good CRC and good length.
- `cnt_crc_err` out `CNT_W`: frames with bad CRC.
- `cnt_len_err` out `CNT_W`: frames with bad length.

## Operation
**Handshakes**
- Output is a single register stage.
- `in_ready = !out_valid || out_ready`.
- A registered output beat holds `out_data`, `out_last` and `out_err` stable until `out_valid && out_ready`.

**States**
- `RECV`: default state.
- `DISCARD`: entered on oversize; left for `RECV` when `in_last` is accepted.

**Per accepted byte**
- `cnt` is the 16-bit accepted-byte count for the frame, saturating at 0xFFFF.
- A 4-byte delay line shifts: d0 holds the newest byte, d3 the oldest.

**CRC**
- When `cnt` > 4, the byte shifted out of d3 updates the CRC with `crc32_eth_update`.
- The CRC starts at `crc32_eth_init()`.

**Forwarding (`RECV` only)**
- `STRIP_FCS=1`: the byte leaving d3 is forwarded, i.e. byte N−4 on acceptance of byte N. Frames of ≤4 bytes forward nothing.
- `STRIP_FCS=0`: the accepted byte itself is forwarded.

**Completion (`in_last` accepted, in `RECV` or `DISCARD`)**
- Length: `len = cnt` including this byte; `bad_len = len < MIN_LEN || len > MAX_LEN`.
- Received FCS: `{in_data, d0, d1, d2}`, little-endian on the wire.
- Computed FCS: `crc32_eth_final(crc updated with the outgoing d3 byte if len > 4)`.
- `bad_crc`: computed FCS ≠ received FCS; forced to 1 if len < 4.
- `out_err = bad_crc || bad_len` on the final beat, which carries `out_last=1`.
- Status pulses: `frame_good = !bad_crc && !bad_len`. `frame_bad_crc` and `frame_bad_len` pulse independently, and both may pulse together.
- Delay line, CRC and `cnt` reinitialise for the next frame.

**Oversize**
- Trigger: the accepted byte makes `cnt == MAX_LEN+1` and `in_last` is 0.
- That cycle's forwarded beat gets `out_last=1`, `out_err=1`, and the block enters `DISCARD`.
- In `DISCARD`, bytes are accepted with no output beats.
- At the frame's `in_last`: `frame_bad_len` pulses and `frame_len_total = len`. `frame_bad_crc` follows the same CRC rule.

**Counters**
- Saturate at all-ones.
- `stat_clr` in the same cycle as an increment: the counter becomes 1.

## Timing
**Reset values**
- All outputs 0, except `in_ready`, which is 1 (the output register is empty).
- `frame_len_total = 0`; all counters 0; state `RECV`; CRC at init.

**Latency**
- Forwarded beats appear one cycle after the acceptance of the byte that produces them.
- Status pulses, `frame_len_total` and counters update in the same cycle as the last output beat, which is one cycle after the `in_last` acceptance.
- Frames of ≤4 bytes with `STRIP_FCS=1` produce status only.

**Boundary conditions**
- Back-to-back frames need no idle cycle: the byte after an `in_last` is byte 1 of the next frame.
- Reset mid-frame: the partial frame is discarded with no status pulse. The next accepted byte starts a new frame.

## Test plan
- 64-byte frame with correct FCS, `STRIP_FCS=1`, `out_ready=1`: 60 beats, last with `out_last=1`, `out_err=0`. `frame_good` pulses, `frame_len_total=64`, `cnt_good=1`.
- Same frame with byte 10 flipped: 60 beats, `out_err=1`. `frame_bad_crc` pulses only; `cnt_crc_err=1`.
- 60-byte frame with valid FCS: 56 beats, `out_err=1`. `frame_bad_len` pulses, `frame_bad_crc` stays 0, `frame_len_total=60`.
- 1600-byte frame, `STRIP_FCS=1`: 1515 beats, the 1515th with `out_last=1`, `out_err=1`. Then `DISCARD`; `frame_bad_len` pulses after byte 1600, `frame_len_total=1600`.
- 64-byte frame with `out_ready` toggled randomly (50%): output bytes are identical to the unstalled run, no beat is lost or duplicated, and `in_ready` is low exactly when `out_valid && !out_ready`.
- 3-byte frame, then `stat_clr` coincident with a good-frame completion: the 3-byte frame gives no beats and pulses both `frame_bad_len` and `frame_bad_crc`. After the clear, `cnt_good=1`, `cnt_crc_err=0`, `cnt_len_err=0`.

Source files
------------

// File: rtl/mac_rx_stream.sv
// Receive MAC for the byte-stream datapath: CRC-32/length check, optional FCS strip,
// oversize truncation, one-stage backpressured output and saturating frame statistics.
module mac_rx_stream #(
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAX_LEN   = 1518,
  parameter int unsigned STRIP_FCS = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_err,
  output logic             frame_good,
  output logic             frame_bad_crc,
  output logic             frame_bad_len,
  output logic [15:0]      frame_len_total,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_crc_err,
  output logic [CNT_W-1:0] cnt_len_err
);

  localparam int unsigned LEN_W    = 16;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic {RECV, DISCARD} state_e;

  function automatic logic [31:0] crc32_eth_init();
    return CRC_INIT;
  endfunction

  // Reflected CRC-32 (poly 0x04C11DB7), one byte LSB first.
  function automatic logic [31:0] crc32_eth_update(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc32_eth_final(input logic [31:0] crc);
    return ~crc;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c, input logic inc,
                                                input logic clr);
    if (clr) return inc ? CNT_W'(1) : '0;
    if (inc && (c != '1)) return c + CNT_W'(1);
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [31:0]      crc_q, crc_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d, out_err_q, out_err_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             good_q, good_d, bad_crc_q, bad_crc_d, bad_len_q, bad_len_d;
  logic [LEN_W-1:0] len_total_q, len_total_d;
  logic [CNT_W-1:0] cnt_good_q, cnt_good_d, cnt_crc_q, cnt_crc_d, cnt_len_q, cnt_len_d;

  logic             accept, beat, oversize, bad_len, bad_crc;
  logic [LEN_W-1:0] cnt_new;
  logic [31:0]      crc_step, fcs_calc, fcs_rx;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign cnt_new  = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);
  // Only bytes that have left the 4-byte window belong to the CRC'd region.
  assign crc_step = (cnt_new > LEN_W'(4)) ? crc32_eth_update(crc_q, d3_q) : crc_q;
  assign fcs_calc = crc32_eth_final(crc_step);
  assign fcs_rx   = {in_data, d0_q, d1_q, d2_q};
  assign bad_len  = (32'(cnt_new) < MIN_LEN) || (32'(cnt_new) > MAX_LEN);
  assign bad_crc  = (cnt_new < LEN_W'(4)) || (fcs_calc != fcs_rx);
  assign oversize = accept && !in_last && (state_q == RECV) && (32'(cnt_new) == MAX_LEN + 32'd1);
  assign beat     = accept && (state_q == RECV) && ((STRIP_FCS == 0) || (cnt_new > LEN_W'(4)));

  // Next-state, datapath and output register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    d3_d        = d3_q;
    crc_d       = crc_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    good_d      = 1'b0;
    bad_crc_d   = 1'b0;
    bad_len_d   = 1'b0;
    len_total_d = len_total_q;
    cnt_good_d  = cnt_next(cnt_good_q, 1'b0, stat_clr);
    cnt_crc_d   = cnt_next(cnt_crc_q, 1'b0, stat_clr);
    cnt_len_d   = cnt_next(cnt_len_q, 1'b0, stat_clr);

    if (accept) begin
      cnt_d = cnt_new;
      d0_d  = in_data;
      d1_d  = d0_q;
      d2_d  = d1_q;
      d3_d  = d2_q;
      crc_d = crc_step;
      if (beat) begin
        out_valid_d = 1'b1;
        out_data_d  = (STRIP_FCS != 0) ? d3_q : in_data;
        out_last_d  = in_last || oversize;
        out_err_d   = in_last ? (bad_crc || bad_len) : oversize;
      end
      if (oversize) state_d = DISCARD;
      if (in_last) begin
        state_d     = RECV;
        cnt_d       = '0;
        d0_d        = '0;
        d1_d        = '0;
        d2_d        = '0;
        d3_d        = '0;
        crc_d       = crc32_eth_init();
        good_d      = !bad_crc && !bad_len;
        bad_crc_d   = bad_crc;
        bad_len_d   = bad_len;
        len_total_d = cnt_new;
        cnt_good_d  = cnt_next(cnt_good_q, !bad_crc && !bad_len, stat_clr);
        cnt_crc_d   = cnt_next(cnt_crc_q, bad_crc, stat_clr);
        cnt_len_d   = cnt_next(cnt_len_q, bad_len, stat_clr);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RECV;
      cnt_q       <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      crc_q       <= CRC_INIT;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      good_q      <= 1'b0;
      bad_crc_q   <= 1'b0;
      bad_len_q   <= 1'b0;
      len_total_q <= '0;
      cnt_good_q  <= '0;
      cnt_crc_q   <= '0;
      cnt_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      crc_q       <= crc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
      good_q      <= good_d;
      bad_crc_q   <= bad_crc_d;
      bad_len_q   <= bad_len_d;
      len_total_q <= len_total_d;
      cnt_good_q  <= cnt_good_d;
      cnt_crc_q   <= cnt_crc_d;
      cnt_len_q   <= cnt_len_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_last        = out_last_q;
  assign out_err         = out_err_q;
  assign frame_good      = good_q;
  assign frame_bad_crc   = bad_crc_q;
  assign frame_bad_len   = bad_len_q;
  assign frame_len_total = len_total_q;
  assign cnt_good        = cnt_good_q;
  assign cnt_crc_err     = cnt_crc_q;
  assign cnt_len_err     = cnt_len_q;

endmodule

// File: tb/tb_mac_rx_stream.sv
// Self-checking bench for mac_rx_stream (defaults: MIN 64, MAX 1518, FCS stripped).
module tb_mac_rx_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_last, out_err;
  logic [7:0]  out_data;
  logic        frame_good, frame_bad_crc, frame_bad_len;
  logic [15:0] frame_len_total;
  logic        stat_clr;
  logic [31:0] cnt_good, cnt_crc_err, cnt_len_err;

  mac_rx_stream dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err),
    .frame_good(frame_good), .frame_bad_crc(frame_bad_crc), .frame_bad_len(frame_bad_len),
    .frame_len_total(frame_len_total), .stat_clr(stat_clr),
    .cnt_good(cnt_good), .cnt_crc_err(cnt_crc_err), .cnt_len_err(cnt_len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       e;
  } beat_t;

  typedef struct {
    int len;
    int flip;
    bit fcs_ok;
    bit stall;
    int beats;
    bit err;
    int g;
    int c;
    int l;
    bit pwl;
  } vec_t;

  int    total = 0;
  int    bad = 0;
  beat_t beat_q[$];
  int    ev_cnt = 0, g_cnt = 0, c_cnt = 0, l_cnt = 0, ir_bad = 0;
  bit    pwl = 1'b0;
  bit    stall_en = 1'b0;
  logic [7:0] frm [0:2047];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bit-serial Ethernet CRC over frm[0..n-1], result already inverted.
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ frm[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    return ~c;
  endfunction

  task automatic build_frame(input int len, input int flip, input bit fcs_ok, input int seed);
    int          np;
    logic [31:0] f;
    np = fcs_ok ? len - 4 : len;
    for (int i = 0; i < np; i++) frm[i] = 8'((i * 37 + 11 + seed * 53) & 255);
    if (fcs_ok) begin
      f = ref_crc(np);
      frm[np]     = f[7:0];
      frm[np + 1] = f[15:8];
      frm[np + 2] = f[23:16];
      frm[np + 3] = f[31:24];
    end
    if (flip > 0) frm[flip - 1] = frm[flip - 1] ^ 8'h5A;
  endtask

  // Entered and left at posedge+1.
  task automatic send_bytes(input int n, input bit do_last, input bit clr_last);
    bit acc;
    int guard;
    bit timeout;
    timeout = 1'b0;
    for (int i = 0; i < n && !timeout; i++) begin
      in_valid = 1'b1;
      in_data  = frm[i];
      in_last  = do_last && (i == n - 1);
      stat_clr = clr_last && (i == n - 1);
      acc   = 1'b0;
      guard = 0;
      while (!acc && !timeout) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        guard++;
        if (guard > 1000) timeout = 1'b1;
      end
    end
    if (timeout) chk("send_timeout", 1, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    stat_clr = 1'b0;
  endtask

  task automatic wait_done(input int ev_before);
    int  n;
    bit  seen;
    seen = 1'b0;
    for (n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (ev_cnt > ev_before) seen = 1'b1;
    end
    if (!seen) chk("status_timeout", 0, 1);
    seen = 1'b0;
    for (n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (!out_valid) seen = 1'b1;
    end
    if (!seen) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_beats(input int base, input int exp_n, input bit exp_err);
    int nact, nbad, nlast;
    nact  = beat_q.size() - base;
    nbad  = 0;
    nlast = 0;
    chk("beat_count", nact, exp_n);
    for (int k = 0; k < nact && k < exp_n; k++) begin
      if (beat_q[base + k].d !== frm[k]) nbad++;
      if (beat_q[base + k].l === 1'b1) nlast++;
    end
    chk("beat_data", nbad, 0);
    chk("last_count", nlast, (exp_n > 0) ? 1 : 0);
    if (exp_n > 0 && nact > 0) begin
      chk("last_pos", int'(beat_q[beat_q.size() - 1].l), 1);
      chk("last_err", int'(beat_q[beat_q.size() - 1].e), int'(exp_err));
    end
  endtask

  // Output monitor and in_ready rule, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) beat_q.push_back('{d: out_data, l: out_last, e: out_err});
      if (frame_good || frame_bad_crc || frame_bad_len) begin
        ev_cnt++;
        pwl = out_valid && out_last;
      end
      if (frame_good) g_cnt++;
      if (frame_bad_crc) c_cnt++;
      if (frame_bad_len) l_cnt++;
      if (in_ready !== !(out_valid && !out_ready)) ir_bad++;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    vec_t tbl[10];
    int   base, g0, c0, l0, e0;

    tbl[0] = '{len: 64,   flip: 0,  fcs_ok: 1, stall: 0, beats: 60,   err: 0, g: 1, c: 0, l: 0, pwl: 1};
    tbl[1] = '{len: 64,   flip: 10, fcs_ok: 1, stall: 0, beats: 60,   err: 1, g: 0, c: 1, l: 0, pwl: 1};
    tbl[2] = '{len: 60,   flip: 0,  fcs_ok: 1, stall: 0, beats: 56,   err: 1, g: 0, c: 0, l: 1, pwl: 1};
    tbl[3] = '{len: 1518, flip: 0,  fcs_ok: 1, stall: 0, beats: 1514, err: 0, g: 1, c: 0, l: 0, pwl: 1};
    tbl[4] = '{len: 1519, flip: 0,  fcs_ok: 1, stall: 0, beats: 1515, err: 1, g: 0, c: 0, l: 1, pwl: 1};
    tbl[5] = '{len: 1600, flip: 0,  fcs_ok: 1, stall: 0, beats: 1515, err: 1, g: 0, c: 0, l: 1, pwl: 0};
    tbl[6] = '{len: 3,    flip: 0,  fcs_ok: 0, stall: 0, beats: 0,    err: 0, g: 0, c: 1, l: 1, pwl: 0};
    tbl[7] = '{len: 4,    flip: 0,  fcs_ok: 1, stall: 0, beats: 0,    err: 0, g: 0, c: 0, l: 1, pwl: 0};
    tbl[8] = '{len: 5,    flip: 0,  fcs_ok: 1, stall: 0, beats: 1,    err: 1, g: 0, c: 0, l: 1, pwl: 1};
    tbl[9] = '{len: 64,   flip: 0,  fcs_ok: 1, stall: 1, beats: 60,   err: 0, g: 1, c: 0, l: 0, pwl: 1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    stat_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last_err", int'({out_last, out_err}), 0);
    chk("rst_pulses", int'({frame_good, frame_bad_crc, frame_bad_len}), 0);
    chk("rst_len_total", int'(frame_len_total), 0);
    chk("rst_counters", int'(cnt_good | cnt_crc_err | cnt_len_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int t = 0; t < 10; t++) begin
      build_frame(tbl[t].len, tbl[t].flip, tbl[t].fcs_ok, t);
      stall_en = tbl[t].stall;
      base = beat_q.size();
      g0 = g_cnt; c0 = c_cnt; l0 = l_cnt; e0 = ev_cnt;
      send_bytes(tbl[t].len, 1'b1, 1'b0);
      wait_done(e0);
      stall_en = 1'b0;
      check_beats(base, tbl[t].beats, tbl[t].err);
      chk($sformatf("v%0d_good", t), g_cnt - g0, tbl[t].g);
      chk($sformatf("v%0d_bad_crc", t), c_cnt - c0, tbl[t].c);
      chk($sformatf("v%0d_bad_len", t), l_cnt - l0, tbl[t].l);
      chk($sformatf("v%0d_len_total", t), int'(frame_len_total), tbl[t].len);
      chk($sformatf("v%0d_status_with_last", t), int'(pwl), int'(tbl[t].pwl));
    end
    chk("cnt_good_sum", int'(cnt_good), 3);
    chk("cnt_crc_sum", int'(cnt_crc_err), 2);
    chk("cnt_len_sum", int'(cnt_len_err), 6);

    // stat_clr on the same cycle as a good completion leaves cnt_good at 1.
    build_frame(64, 0, 1'b1, 20);
    e0 = ev_cnt;
    send_bytes(64, 1'b1, 1'b1);
    wait_done(e0);
    chk("clr_cnt_good", int'(cnt_good), 1);
    chk("clr_cnt_crc", int'(cnt_crc_err), 0);
    chk("clr_cnt_len", int'(cnt_len_err), 0);

    // Back-to-back frames without an idle cycle.
    base = beat_q.size();
    g0 = g_cnt; e0 = ev_cnt;
    build_frame(64, 0, 1'b1, 21);
    send_bytes(64, 1'b1, 1'b0);
    build_frame(70, 0, 1'b1, 22);
    send_bytes(70, 1'b1, 1'b0);
    wait_done(e0 + 1);
    chk("b2b_beats", beat_q.size() - base, 60 + 66);
    chk("b2b_good", g_cnt - g0, 2);
    chk("b2b_len_total", int'(frame_len_total), 70);
    chk("b2b_cnt_good", int'(cnt_good), 3);

    // Reset mid-frame discards the partial frame silently.
    build_frame(64, 0, 1'b1, 23);
    e0 = ev_cnt;
    send_bytes(30, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_status", ev_cnt - e0, 0);
    chk("mid_rst_counters", int'(cnt_good | cnt_crc_err | cnt_len_err), 0);
    chk("mid_rst_len_total", int'(frame_len_total), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    build_frame(64, 0, 1'b1, 24);
    base = beat_q.size();
    g0 = g_cnt; e0 = ev_cnt;
    send_bytes(64, 1'b1, 1'b0);
    wait_done(e0);
    check_beats(base, 60, 1'b0);
    chk("post_rst_good", g_cnt - g0, 1);
    chk("post_rst_cnt_good", int'(cnt_good), 1);
    chk("post_rst_len_total", int'(frame_len_total), 64);

    chk("in_ready_rule", ir_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
